// File: rtl/instruction_decode.sv
// RV64I decode stage: registers fetched word/PC, reads operands with writeback bypass, builds immediates and control.
// Latency one cycle; stall_in freezes the bundle, flush and load-use hazards insert a bubble and hold fetch.
module instruction_decode #(
    parameter int XLEN     = 64,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_instr,
    input  logic [XLEN-1:0]     if_pc,
    input  logic                stall_in,
    input  logic                flush,
    output logic                stall_out,
    output logic [4:0]          rf_rs1_addr,
    output logic [4:0]          rf_rs2_addr,
    input  logic [XLEN-1:0]     rf_rs1_data,
    input  logic [XLEN-1:0]     rf_rs2_data,
    input  logic                wb_en,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                ex_valid,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_rd,
    output logic                id_valid,
    output logic [XLEN-1:0]     id_pc,
    output logic [XLEN-1:0]     id_rs1_val,
    output logic [XLEN-1:0]     id_rs2_val,
    output logic [XLEN-1:0]     id_imm,
    output logic [4:0]          id_rd,
    output logic                id_reg_write,
    output logic [2:0]          id_class,
    output logic [ALU_OP_W-1:0] id_alu_op,
    output logic [2:0]          id_funct3,
    output logic                id_is_word,
    output logic                id_is_auipc,
    output logic                id_illegal
);
    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;

    localparam logic [2:0] CLS_OP     = 3'd0;
    localparam logic [2:0] CLS_OP_IMM = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_UPPER  = 3'd7;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] funct6;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];
    assign funct6 = if_instr[31:26];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    logic [2:0]          dec_class;
    logic [XLEN-1:0]     dec_imm;
    logic                dec_illegal;
    logic                dec_writes;
    logic                uses_rs1;
    logic                uses_rs2;
    logic [ALU_OP_W-1:0] dec_alu_op;

    always_comb begin
        dec_class   = CLS_OP;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        dec_writes  = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        dec_alu_op  = '0;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                dec_writes  = 1'b1;
                dec_alu_op  = ALU_OP_W'({funct7[5], funct3});
                // funct7=0x20 is only meaningful for SUB and SRA
                dec_illegal = !((funct7 == 7'h00) ||
                                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
                if (opcode == OPC_OP_32 && !(funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_class  = CLS_OP_IMM;
                uses_rs1   = 1'b1;
                dec_writes = 1'b1;
                dec_imm    = imm_i;
                dec_alu_op = ALU_OP_W'({(funct3 == 3'd5) & funct7[5], funct3});
                if (funct3 == 3'd1)
                    dec_illegal = (funct6 != 6'h00);
                else if (funct3 == 3'd5)
                    dec_illegal = (funct6 != 6'h00) && (funct6 != 6'h10);
            end
            OPC_OP_IMM_32: begin
                dec_class   = CLS_OP_IMM;
                uses_rs1    = 1'b1;
                dec_writes  = 1'b1;
                dec_imm     = imm_i;
                dec_alu_op  = ALU_OP_W'({(funct3 == 3'd5) & funct7[5], funct3});
                // 32-bit shifts have a 5-bit shamt, so instr[25] must be clear
                dec_illegal = !((funct3 == 3'd0) ||
                                (funct3 == 3'd1 && funct7 == 7'h00) ||
                                (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)));
            end
            OPC_LOAD: begin
                dec_class   = CLS_LOAD;
                uses_rs1    = 1'b1;
                dec_writes  = 1'b1;
                dec_imm     = imm_i;
                dec_illegal = (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec_class   = CLS_STORE;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                dec_imm     = imm_s;
                dec_illegal = funct3[2];
            end
            OPC_BRANCH: begin
                dec_class   = CLS_BRANCH;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                dec_imm     = imm_b;
                dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_JAL: begin
                dec_class  = CLS_JAL;
                dec_writes = 1'b1;
                dec_imm    = imm_j;
            end
            OPC_JALR: begin
                dec_class   = CLS_JALR;
                uses_rs1    = 1'b1;
                dec_writes  = 1'b1;
                dec_imm     = imm_i;
                dec_illegal = (funct3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_class  = CLS_UPPER;
                dec_writes = 1'b1;
                dec_imm    = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (wb_en && wb_rd == rs1) ? wb_data : rf_rs1_data;
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (wb_en && wb_rd == rs2) ? wb_data : rf_rs2_data;

    logic load_use;

    assign load_use = if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1 && uses_rs1) || (ex_rd == rs2 && uses_rs2));

    assign stall_out = stall_in | (load_use & ~flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_rd        <= '0;
            id_reg_write <= 1'b0;
            id_class     <= '0;
            id_alu_op    <= '0;
            id_funct3    <= '0;
            id_is_word   <= 1'b0;
            id_is_auipc  <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (stall_in) begin
            id_valid <= id_valid;
        end else if (load_use) begin
            id_valid <= 1'b0;
        end else begin
            id_valid     <= if_valid;
            id_pc        <= if_pc;
            id_rs1_val   <= rs1_val;
            id_rs2_val   <= rs2_val;
            id_imm       <= dec_imm;
            id_rd        <= rd;
            id_reg_write <= dec_writes && (rd != 5'd0) && !dec_illegal;
            id_class     <= dec_class;
            id_alu_op    <= dec_alu_op;
            id_funct3    <= funct3;
            id_is_word   <= (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
            id_is_auipc  <= (opcode == OPC_AUIPC);
            id_illegal   <= dec_illegal;
        end
    end
endmodule
